// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access-size
// encodings and byte-lane offsets.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_DONE,
    ST_FAULT
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 also treated as word

  // Little-endian lane offsets within a word.
  localparam logic [1:0] OFF_B0  = 2'd0;
  localparam logic [1:0] HALF_LO = 2'd0;
  localparam logic [1:0] HALF_HI = 2'd2;

  // Any size with bit 1 set is a full-word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/half
// of a loaded word, and merges store data into the addressed lane.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Load path: select lane, then sign- or zero-extend.
  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = (offset == HALF_HI) ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: load_data = rdata;
    endcase
  end

  // Store path: replace only the addressed lane of the captured word.
  always_comb begin
    store_word = old_word;
    case (size)
      SZ_BYTE: store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (offset == HALF_HI) store_word[31:16] = wdata[15:0];
        else                   store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: single-outstanding access FSM with
// read-modify-write for sub-word stores and range/alignment faults.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of having their low address bits silently cleared.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_next;
  logic        load_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rmw_q, rdata_q;
  logic [31:0] load_data, store_word;
  logic        out_of_range, misalign, bad;
  logic [1:0]  eff_off;

  // Request checks and effective lane offset for the incoming address.
  always_comb begin
    out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (req_size == SZ_HALF && req_addr[0]) ||
               (is_word(req_size) && req_addr[1:0] != 2'b00);
    eff_off  = req_addr[1:0];
`else
    misalign = 1'b0;
    if (is_word(req_size))        eff_off = OFF_B0;
    else if (req_size == SZ_HALF) eff_off = {req_addr[1], 1'b0};
    else                          eff_off = req_addr[1:0];
`endif
    bad = out_of_range | misalign;
  end

  lsu_lane_align u_align (
    .size      (size_q),
    .sign_ext  (signed_q),
    .offset    (addr_q[1:0]),
    .rdata     (mem_rdata),
    .old_word  (rmw_q),
    .wdata     (wdata_q),
    .load_data (load_data),
    .store_word(store_word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    fault      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                    state_next = ST_FAULT;
          else if (req_load)          state_next = ST_LOAD;
          else if (is_word(req_size)) state_next = ST_WRITE;
          else                        state_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   begin mem_read  = 1'b1; state_next = ST_DONE;  end
      ST_RMW_RD: begin mem_read  = 1'b1; state_next = ST_WRITE; end
      ST_WRITE:  begin mem_write = 1'b1; state_next = ST_DONE;  end
      ST_DONE:   begin resp_valid = 1'b1; state_next = ST_IDLE; end
      ST_FAULT:  begin resp_valid = 1'b1; fault = 1'b1; state_next = ST_IDLE; end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Request latch, load result and RMW capture; result clears on accept so
  // stores and faults respond with zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q   <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rmw_q    <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          load_q   <= req_load;
          signed_q <= req_signed;
          size_q   <= req_size;
          addr_q   <= {req_addr[31:2], eff_off};
          wdata_q  <= req_wdata;
          rdata_q  <= '0;
        end
        ST_LOAD:   rdata_q <= load_data;
        ST_RMW_RD: rmw_q   <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign stall      = (state != ST_IDLE);
  assign resp_rdata = rdata_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = (state == ST_WRITE && !load_q) ? store_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  localparam int MW = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_load = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, fault, stall, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [MW];
  logic        init_mem = 1'b0;
  int          wr_count = 0;
  int          checks = 0, errors = 0;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .fault(fault), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_addr[31:2] < MW) mem_rdata = mem[mem_addr[14:2]];
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MW; i++) mem[i] <= i;
      mem[5] <= 32'h80FF7F01;
    end else if (mem_write) begin
      wr_count <= wr_count + 1;
      if (mem_addr[31:2] < MW) mem[mem_addr[14:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: drive, accept, then watch strobes until the response.
  task automatic access(input logic ld, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic flt,
                        output int nrd, output int nwr);
    logic done;
    int   bad;
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    chk("resp_quiet", {30'b0, resp_valid, fault}, 32'd0);
    req_valid = 1'b1; req_load = ld; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; bad = 0; done = 1'b0; rd = '0; flt = 1'b0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if ((mem_read && mem_write) || !stall) bad++;
      if (resp_valid) begin done = 1'b1; rd = resp_rdata; flt = fault; end
    end
    chk("resp_seen", {31'b0, done}, 32'd1);
    chk("stall_strobe_rules", bad, 0);
  endtask

  int lat, nrd, nwr, wr0;
  logic [31:0] rd;
  logic flt;

  initial begin
    #1 rst = 1'b1;
    init_mem = 1'b1;
    #1;
    chk("rst_outputs", {req_ready, resp_valid, fault, mem_read, mem_write, stall}, {26'b0, 6'b100000});
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 init_mem = 1'b0;
    rst = 1'b0;

    access(1, 2'b10, 0, 32'h10, 0, lat, rd, flt, nrd, nwr);
    chk("lw_data", rd, 32'h4);
    chk("lw_lat", lat, 2);
    chk("lw_rd", nrd, 1);
    chk("lw_wr", nwr, 0);

    access(1, 2'b00, 1, 32'h15, 0, lat, rd, flt, nrd, nwr);
    chk("lb_15", rd, 32'h0000007F);
    access(1, 2'b00, 1, 32'h17, 0, lat, rd, flt, nrd, nwr);
    chk("lb_17", rd, 32'hFFFFFF80);
    access(1, 2'b00, 0, 32'h17, 0, lat, rd, flt, nrd, nwr);
    chk("lbu_17", rd, 32'h00000080);
    access(1, 2'b01, 0, 32'h16, 0, lat, rd, flt, nrd, nwr);
    chk("lhu_16", rd, 32'h000080FF);
    access(1, 2'b01, 1, 32'h16, 0, lat, rd, flt, nrd, nwr);
    chk("lh_16", rd, 32'hFFFF80FF);
    access(1, 2'b01, 1, 32'h14, 0, lat, rd, flt, nrd, nwr);
    chk("lh_14", rd, 32'h00007F01);
    access(1, 2'b11, 0, 32'h10, 0, lat, rd, flt, nrd, nwr);
    chk("lw_size11", rd, 32'h4);

    access(0, 2'b00, 0, 32'h21, 32'h123456AA, lat, rd, flt, nrd, nwr);
    chk("sb_lat", lat, 3);
    chk("sb_rd", nrd, 1);
    chk("sb_wr", nwr, 1);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_mem", mem[8], 32'h0000AA08);

    access(0, 2'b01, 0, 32'h22, 32'h0000BEEF, lat, rd, flt, nrd, nwr);
    chk("sh_mem", mem[8], 32'hBEEFAA08);

    access(0, 2'b10, 0, 32'h24, 32'h12345678, lat, rd, flt, nrd, nwr);
    chk("sw_lat", lat, 2);
    chk("sw_rd", nrd, 0);
    chk("sw_mem", mem[9], 32'h12345678);

    access(1, 2'b10, 0, 32'h13, 0, lat, rd, flt, nrd, nwr);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_fault", {31'b0, flt}, 32'd1);
    chk("mis_lat", lat, 1);
    chk("mis_strobes", nrd + nwr, 0);
    chk("mis_rdata", rd, 32'h0);
`else
    chk("mis_fault", {31'b0, flt}, 32'd0);
    chk("mis_data", rd, 32'h4);
    chk("mis_lat", lat, 2);
`endif

    access(0, 2'b10, 0, 32'h8000, 32'hDEADBEEF, lat, rd, flt, nrd, nwr);
    chk("oor_fault", {31'b0, flt}, 32'd1);
    chk("oor_lat", lat, 1);
    chk("oor_wr", nwr, 0);
    chk("oor_rdata", rd, 32'h0);

    // Reset in the middle of a byte store's read phase.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_phase", {30'b0, mem_read, mem_write}, 32'd2);
    wr0 = wr_count;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {req_ready, stall, mem_write, mem_read, resp_valid}, {27'b0, 5'b10000});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_write", wr_count, wr0);
    chk("abort_mem", mem[12], 32'd12);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 8192, data memory depth in 32-bit words; word index >= MEM_WORDS is out of range.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_valid  in  1  MEM-stage access request present.
REQ-005 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 req_load  in  1  1 = load, 0 = store.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 req_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load result; 0 for stores and faults.
REQ-013 fault  out  1  one-cycle pulse, misaligned or out-of-range access.
REQ-014 stall  out  1  high whenever state != IDLE; freezes the pipeline.
REQ-015 mem_addr  out  32  word-aligned address to data memory ({addr[31:2],2'b00}).
REQ-016 mem_wdata  out  32  full word to data memory.
REQ-017 mem_read / mem_write  out  1 each  data memory strobes.
REQ-018 mem_rdata  in  32  data memory read word, valid in the same cycle as mem_read.

Function
REQ-019 FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE, FAULT.
REQ-020 IDLE: on req_valid, latch the request; on fault go to FAULT, else load -> LOAD, word store -> WRITE, byte/half store -> RMW_RD.
REQ-021 LOAD: mem_read=1; register the extracted and extended lane into resp_rdata; -> DONE.
REQ-022 RMW_RD: mem_read=1; capture mem_rdata; -> WRITE.
REQ-023 WRITE: mem_write=1 for exactly one cycle; mem_wdata = captured word with the target lane replaced, or req_wdata for word stores; -> DONE.
REQ-024 DONE: resp_valid=1 for one cycle; -> IDLE. FAULT: fault=1, resp_valid=1, resp_rdata=0, no mem strobe; -> IDLE.
REQ-025 Latency from accept edge to resp_valid: load 2 cycles, word store 2, sub-word store 3, fault 1.
REQ-026 Byte lanes are little-endian: byte offset 0 = bits 7:0; half offset 0 = bits 15:0, offset 2 = bits 31:16.
REQ-027 Out-of-range means req_addr[31:2] >= MEM_WORDS; it always faults, independent of the configuration macro.
REQ-028 mem_read and mem_write are never both high; both are 0 outside LOAD, RMW_RD and WRITE.
REQ-029 req_valid outside IDLE is ignored; the pipeline holds it stable via stall.

Reset
REQ-030 rst forces IDLE immediately; resp_valid, fault, mem_read, mem_write, resp_rdata, mem_wdata and mem_addr are all 0; req_ready=1.
REQ-031 rst asserted in RMW_RD or WRITE aborts the access; no mem_write is issued after rst rises, and the partial RMW is discarded.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 faults.
REQ-033 Macro LSU_MISALIGN_TRAP_EN undefined: misaligned low address bits are silently cleared to the access size and the access proceeds with no fault.

Structure
REQ-034 Package lsu_pkg holds the FSM state enum, the req_size encodings and the lane-offset constants.
REQ-035 Sub-module lsu_lane_align is purely combinational: load lane extraction with extension, and store lane merge.

Verification
REQ-036 Memory preloaded with M[i]=i. Load word at 0x10 -> resp_rdata=0x00000004 two cycles after accept, with stall high in between.
REQ-037 M[5]=0x80FF7F01. Signed byte load at 0x15 -> 0x0000007F; signed byte load at 0x17 -> 0xFFFFFF80; unsigned half load at 0x16 -> 0x000080FF.
REQ-038 Sub-word stores:
- Store byte 0xAA at 0x21 with M[8]=0x00000008 -> one RMW_RD cycle, one WRITE cycle, then M[8]=0x0000AA08.
- Store half 0xBEEF at 0x22 -> M[8] upper half becomes 0xBEEF.
REQ-039 Misaligned word load at 0x13:
- With LSU_MISALIGN_TRAP_EN: fault and resp_valid pulse one cycle after accept; no mem strobe.
- Without the macro: returns M[4]=4.
REQ-040 Out-of-range store at address 4*MEM_WORDS -> fault=1 and mem_write stays 0.
REQ-041 rst pulse during RMW_RD of a byte store to 0x30 -> mem_write never rises, M[12] is unchanged, and req_ready=1 after reset.
